universal_reg: RTL and testbench



---
 rtl/universal_reg.sv | 107 ++++++++++
 tb/tb_universal_reg.sv | 130 +++++++++++++
 2 files changed

// File: rtl/universal_reg.sv
// Universal WIDTH-bit register: hold, parallel load, shift, rotate and up/down
// count. Also provides the complementary output, a registered carry/shift-out bit and a zero flag.
module universal_reg #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             co,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_co;

  mode_e            w_mode;
  logic [WIDTH-1:0] w_q_next;
  logic             w_co_next;
  logic [WIDTH-1:0] w_q_inc;
  logic [WIDTH-1:0] w_q_dec;
  logic             w_all_ones;
  logic             w_all_zero;

  assign w_mode     = mode_e'(mode);
  assign w_q_inc    = r_q + WIDTH'(1);
  assign w_q_dec    = r_q - WIDTH'(1);
  assign w_all_ones = (r_q == {WIDTH{1'b1}});
  assign w_all_zero = (r_q == '0);

  always_comb begin
    w_q_next  = r_q;
    w_co_next = r_co;
    case (w_mode)
      MODE_HOLD: begin
        w_q_next  = r_q;
        w_co_next = r_co;
      end
      MODE_LOAD: begin
        w_q_next  = d;
        w_co_next = 1'b0;
      end
      MODE_SHL: begin
        w_q_next  = {r_q[WIDTH-2:0], sin};
        w_co_next = r_q[WIDTH-1];
      end
      MODE_SHR: begin
        w_q_next  = {sin, r_q[WIDTH-1:1]};
        w_co_next = r_q[0];
      end
      MODE_ROL: begin
        w_q_next  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_co_next = r_q[WIDTH-1];
      end
      MODE_ROR: begin
        w_q_next  = {r_q[0], r_q[WIDTH-1:1]};
        w_co_next = r_q[0];
      end
      // Carry out of the increment is simply "old value was all ones".
      MODE_INC: begin
        w_q_next  = w_q_inc;
        w_co_next = w_all_ones;
      end
      MODE_DEC: begin
        w_q_next  = w_q_dec;
        w_co_next = w_all_zero;
      end
      default: begin
        w_q_next  = r_q;
        w_co_next = r_co;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q  <= RESET_VALUE;
      r_co <= 1'b0;
    end else if (en) begin
      r_q  <= w_q_next;
      r_co <= w_co_next;
    end
  end

  // q_bar and zero derive from the single q register so they can never disagree with it.
  assign q     = r_q;
  assign q_bar = ~r_q;
  assign co    = r_co;
  assign zero  = (r_q == '0);

endmodule

// File: tb/tb_universal_reg.sv
// Scoreboard bench for universal_reg (WIDTH=8, RESET_VALUE=0): stimulus queues
// hand-computed expectations, a monitor checks them after each rising edge.
module tb_universal_reg;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         co;
  logic         zero;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic         co;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_miss;
  bit   stim_done;

  universal_reg #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .q_bar (q_bar),
    .co    (co),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector for exactly one rising edge and queue what must follow it.
  task automatic apply(input string name, input logic rst_i, input logic en_i,
                       input logic [2:0] mode_i, input logic [W-1:0] d_i,
                       input logic sin_i, input logic [W-1:0] eq, input logic eco);
    exp_t e;
    @(negedge clk);
    reset = rst_i;
    en    = en_i;
    mode  = mode_i;
    d     = d_i;
    sin   = sin_i;
    e.name = name;
    e.q    = eq;
    e.co   = eco;
    exp_q.push_back(e);
  endtask

  // Monitor: the register presents a new result after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (q !== e.q) begin
        n_miss++;
        $display("FAIL %s q: got %h expected %h", e.name, q, e.q);
      end
      if (q_bar !== ~e.q) begin
        n_miss++;
        $display("FAIL %s q_bar: got %h expected %h", e.name, q_bar, ~e.q);
      end
      if (co !== e.co) begin
        n_miss++;
        $display("FAIL %s co: got %b expected %b", e.name, co, e.co);
      end
      if (zero !== (e.q == 8'h00)) begin
        n_miss++;
        $display("FAIL %s zero: got %b expected %b", e.name, zero, (e.q == 8'h00));
      end
      $display("vec %0d %s: q=%h q_bar=%h co=%b zero=%b", n_vec, e.name, q, q_bar, co, zero);
    end
  end

  initial begin
    n_vec = 0; n_miss = 0; stim_done = 1'b0;
    reset = 1'b1; en = 1'b0; mode = 3'b000; d = '0; sin = 1'b0;

    //       name          rst en  mode    d      sin   q      co
    apply("reset_prio",   1, 1, 3'b001, 8'hFF, 1'b1, 8'h00, 1'b0);
    apply("load_a5",      0, 1, 3'b001, 8'hA5, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++)
      apply("en0_hold",   0, 0, 3'b001, 8'h00, 1'b0, 8'hA5, 1'b0);
    apply("shl_sin1",     0, 1, 3'b010, 8'h00, 1'b1, 8'h4B, 1'b1);
    apply("shr_sin0",     0, 1, 3'b011, 8'hFF, 1'b0, 8'h25, 1'b1);
    apply("en0_co_hold",  0, 0, 3'b111, 8'h00, 1'b0, 8'h25, 1'b1);
    apply("mode_hold",    0, 1, 3'b000, 8'hFF, 1'b1, 8'h25, 1'b1);
    apply("load_01",      0, 1, 3'b001, 8'h01, 1'b0, 8'h01, 1'b0);
    apply("ror",          0, 1, 3'b101, 8'h00, 1'b0, 8'h80, 1'b1);
    apply("rol_sin_ign",  0, 1, 3'b100, 8'h00, 1'b0, 8'h01, 1'b1);
    apply("rol_sin1",     0, 1, 3'b100, 8'hFF, 1'b1, 8'h02, 1'b0);
    apply("shl_sin0",     0, 1, 3'b010, 8'hFF, 1'b0, 8'h04, 1'b0);
    apply("load_fe",      0, 1, 3'b001, 8'hFE, 1'b0, 8'hFE, 1'b0);
    apply("inc_to_ff",    0, 1, 3'b110, 8'h00, 1'b1, 8'hFF, 1'b0);
    apply("inc_wrap",     0, 1, 3'b110, 8'h00, 1'b0, 8'h00, 1'b1);
    apply("dec_borrow",   0, 1, 3'b111, 8'h00, 1'b0, 8'hFF, 1'b1);
    apply("dec_plain",    0, 1, 3'b111, 8'h00, 1'b0, 8'hFE, 1'b0);
    apply("load_10",      0, 1, 3'b001, 8'h10, 1'b0, 8'h10, 1'b0);
    apply("inc_11",       0, 1, 3'b110, 8'h00, 1'b0, 8'h11, 1'b0);
    apply("rst_mid_cnt",  1, 0, 3'b110, 8'h00, 1'b0, 8'h00, 1'b0);
    apply("inc_after_rst",0, 1, 3'b110, 8'h00, 1'b0, 8'h01, 1'b0);

    @(negedge clk);
    en = 1'b0;
    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
